plic_claim_ctrl: RTL

PLIC_CLAIM_CTRL -- requirements
Module: plic_claim_ctrl

---
 rtl/plic_pkg.sv | 21 ++
 rtl/plic_claim_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/plic_pkg.sv
// Shared definitions for the PLIC claim/complete front end: register word
// offsets, STATUS bit positions and FSM state encoding.
package plic_pkg;

  // Register word index (byte address bits [3:2])
  localparam logic [1:0] REG_CLAIM  = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  // STATUS bit positions
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_ERR_BIT  = 1;
  localparam int STATUS_ID_LSB   = 8;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_SERVICE = 1'b1
  } state_e;

endpackage

// File: rtl/plic_claim_ctrl.sv
// Claim/complete controller between a PLIC and one hart.
// A CLAIM read grabs the best pending source, pulses its one-hot claim line
// and holds it as cur_id until the hart writes cur_id+1 back to CLAIM.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no interrupt in service; meip mirrors int_pending
// ST_SERVICE | cur_id claimed, waiting for a matching completion write
module plic_claim_ctrl
  import plic_pkg::*;
#(
  parameter int PORTS    = 4,
  parameter int ID_WIDTH = $clog2(PORTS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                int_pending,
  input  logic [ID_WIDTH-1:0] int_id,
  output logic [PORTS-1:0]    int_claim,
  output logic                meip,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [3:0]          req_addr,
  input  logic [31:0]         req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [31:0]         rsp_rdata
);

  state_e              state_q, state_d;
  logic [ID_WIDTH-1:0] cur_id_q, cur_id_d;
  logic                err_q, err_d;
  logic [31:0]         claim_count_q, claim_count_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;

  logic                accept;
  logic [1:0]          reg_sel;
  logic                claim_fire;
  logic                err_set;
  logic                err_clr;
  logic [31:0]         read_data;
  logic [31:0]         status_word;
  logic [1:0]          unused_addr_bits;

  assign unused_addr_bits = req_addr[1:0];
  assign req_ready        = !rsp_valid_q || rsp_ready;
  assign accept           = req_valid && req_ready;
  assign reg_sel          = req_addr[3:2];

  // Decode the accepted request, update FSM/register file, build the response
  always_comb begin
    state_d       = state_q;
    cur_id_d      = cur_id_q;
    claim_count_d = claim_count_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    claim_fire    = 1'b0;
    err_set       = 1'b0;
    err_clr       = 1'b0;
    read_data     = '0;

    status_word                                = '0;
    status_word[STATUS_BUSY_BIT]               = (state_q == ST_SERVICE);
    status_word[STATUS_ERR_BIT]                = err_q;
    status_word[STATUS_ID_LSB +: ID_WIDTH]     = cur_id_q;

    if (accept) begin
      case (reg_sel)
        REG_CLAIM: begin
          if (!req_write) begin
            // Only an idle controller with a pending source may claim
            if (state_q == ST_IDLE && int_pending) begin
              claim_fire    = 1'b1;
              read_data     = 32'(int_id) + 32'd1;
              cur_id_d      = int_id;
              claim_count_d = claim_count_q + 32'd1;
              state_d       = ST_SERVICE;
            end
          end else if (state_q == ST_SERVICE &&
                       req_wdata == (32'(cur_id_q) + 32'd1)) begin
            state_d = ST_IDLE;
          end else begin
            err_set = 1'b1;
          end
        end
        REG_STATUS: begin
          if (!req_write) read_data = status_word;
          else            err_clr   = req_wdata[STATUS_ERR_BIT];
        end
        REG_COUNT: begin
          if (!req_write) read_data = claim_count_q;
        end
        default: ;
      endcase
    end

    // A new error outranks a simultaneous clear
    err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);

    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = read_data;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
      rsp_rdata_d = '0;
    end
  end

  // Claim pulse is combinational so it lands in the acceptance cycle itself
  always_comb begin
    int_claim = '0;
    if (claim_fire && rst_n) int_claim = PORTS'(1'b1) << int_id;
  end

  assign meip      = int_pending && (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

  // State and register file flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cur_id_q      <= '0;
      err_q         <= 1'b0;
      claim_count_q <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      cur_id_q      <= cur_id_d;
      err_q         <= err_d;
      claim_count_q <= claim_count_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
    end
  end

endmodule
